seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the display-select mux in the board top level and consumes the selected 32-bit CPU register value. It latches that value once per scan frame to prevent tearing, decodes each nibble to hex glyphs, and scans the digits at a parameterised rate. It runs on the board clock, not the divided CPU clock.

## Interface
- SCAN_DIV, default 50000: board-clock cycles each digit stays selected. Legal range is ≥ 2. Benches use 4.
- clk  in  1  board clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  display enable; 0 blanks all digits.
- i_blank_lz  in  1  1 = suppress leading zeros (digit 0 is never suppressed).
- i_data  in  32  value to display; nibble k drives digit k, and digit 0 is the rightmost.
- o_seg  out  8  active-low segments; bit 7 = dp, bits 6..0 = g..a. dp is always off (1).
- o_sel  out  8  active-low digit select; bit k selects digit k.
- o_frame  out  1  one-cycle pulse each time a new frame value is latched.

## Operation
- div: counter 0..SCAN_DIV-1, incremented every cycle, wraps to 0. tick = (div == SCAN_DIV-1).
- idx: 3-bit digit index. Increments on tick and wraps 7→0.
- boundary = tick && idx == 7.
- shadow: 32-bit frame register.
  - i_en == 0: shadow <= i_data every cycle, so the current value shows as soon as the display is enabled.
  - i_en == 1: shadow <= i_data only on boundary; otherwise it holds.
- o_frame: registered. It is 1 in the cycle after a boundary taken with i_en == 1, and 0 otherwise. In that cycle shadow already holds the new value.
- Scan state machine is implicit in idx (states D0..D7, cyclic). There are no other states.
- Hex decode, active-low, of nibble n = shadow[4*idx+3 : 4*idx]:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
- Leading-zero blank: digit k > 0 is blank when i_blank_lz == 1 and shadow[31 : 4k] == 0.
  - A blank digit has o_seg = FF.
  - o_sel still asserts for a blank digit, so scan timing does not change.
- Output registers, updated every cycle:
  - i_en == 0: o_sel = FF, o_seg = FF.
  - Otherwise: o_sel = ~(1 << idx), o_seg = the glyph (or FF if blanked).
- Disabling does not stop div or idx. Re-enabling resumes from the current idx.

## Timing
- Reset (rst high at an edge): div = 0, idx = 0, shadow = 0, o_seg = FF, o_sel = FF, o_frame = 0.
- rst overrides everything, including mid-frame. The scan restarts at D0 and the pending frame value is discarded.
- Output latency: o_sel and o_seg reflect the div, idx, shadow and i_en values of the previous cycle (1 cycle).
- In the first cycle after reset deassertion with i_en = 1: o_sel = FE, o_seg = C0 (shadow = 0).
- Each digit is shown for exactly SCAN_DIV cycles, so the frame is 8*SCAN_DIV cycles. The first boundary is at cycle 8*SCAN_DIV-1 after reset.
- i_data changes mid-frame are invisible until the next boundary when i_en = 1.
- Simultaneous events:
  - boundary with i_en falling to 0: shadow loads (disabled rule), o_frame stays 0.
  - i_en rising on a boundary cycle: that boundary loads and o_frame pulses.
- i_blank_lz is sampled combinationally each cycle, not latched per frame.

## Test plan
- Reset check, SCAN_DIV = 4: hold rst 3 cycles with i_en = 1 -> o_seg = FF, o_sel = FF, o_frame = 0 during reset. The first post-reset cycle gives o_sel = FE, o_seg = C0. o_sel then steps FE, FD, FB, … 7F, holding each value for 4 cycles.
- Frame latching: i_en = 1, i_data = 12345678 from reset -> all digits show C0 for the first 32 cycles. Then o_frame pulses once, and the next frame shows digit 0 = 80 ('8') through digit 7 = F9 ('1'). Changing i_data to FFFFFFFF mid-frame has no effect until the next o_frame.
- Leading-zero blanking: i_data = 000000A0, i_blank_lz = 1 -> digit 0 = C0, digit 1 = 88, digits 2–7 = FF with their sel bits still asserted. i_data = 00000000 -> digit 0 = C0, all others FF. With i_blank_lz = 0, all eight digits show C0.
- Enable behaviour: drop i_en mid-frame -> outputs are FF/FF on the next cycle. Set i_data = DEADBEEF, then raise i_en -> the next cycle shows the current idx's nibble of DEADBEEF immediately. No o_frame pulse occurs until the next boundary.
- Reset mid-frame: assert rst while idx = 5 with a pending new i_data -> after release, o_sel = FE and o_seg = C0. The new value appears only after 8*SCAN_DIV cycles.
- Full glyph sweep: i_data = FEDCBA98 followed by 76543210 -> all 16 active-low codes appear exactly as tabulated in Operation.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Latches the display value once per scan frame and scans digits every SCAN_DIV cycles.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_blank_lz,
  input  logic [31:0] i_data,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Scan states: the digit index itself is the state, cycling D0..D7.
  localparam logic [2:0] D0 = 3'd0;
  localparam logic [2:0] D7 = 3'd7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             frame_q, frame_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [31:0]      upper;
  logic             lz_blank;

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      4'hF:    g = 8'h8E;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  always_comb begin
    tick     = (div_q == DIV_LAST);
    boundary = tick && (idx_q == D7);

    div_d = tick ? '0 : div_q + DIV_W'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;

    // While disabled the shadow tracks the input so enabling shows it at once.
    shadow_d = (!i_en || boundary) ? i_data : shadow_q;
    frame_d  = boundary && i_en;

    nibble   = shadow_q[{idx_q, 2'b00} +: 4];
    upper    = shadow_q >> {idx_q, 2'b00};
    lz_blank = (idx_q != D0) && i_blank_lz && (upper == 32'd0);

    sel_d = SEG_OFF;
    seg_d = SEG_OFF;
    if (i_en) begin
      sel_d = ~(8'h01 << idx_q);
      seg_d = lz_blank ? SEG_OFF : hex_glyph(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= D0;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      sel_q    <= SEG_OFF;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed steps plus random traffic, every cycle
// compared against a frame-arithmetic reference model.
module tb_seg_scan_driver;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [7:0] DIG_12345678 [8] = '{
    8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_blank_lz;
  logic [31:0] i_data;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_blank_lz (i_blank_lz),
    .i_data     (i_data),
    .o_seg      (o_seg),
    .o_sel      (o_sel),
    .o_frame    (o_frame)
  );

  // Reference model: position in the scan derived from the cycle count since reset.
  int unsigned cyc;
  int          m_digit;
  logic        m_bnd;
  logic [3:0]  m_nib;
  logic        m_blank;
  logic [31:0] m_shadow;
  logic [7:0]  exp_seg;
  logic [7:0]  exp_sel;
  logic        exp_frame;

  always @(posedge clk) begin
    if (rst) begin
      cyc       = 0;
      m_shadow  = 32'd0;
      exp_seg   = 8'hFF;
      exp_sel   = 8'hFF;
      exp_frame = 1'b0;
    end else begin
      m_digit   = (cyc / SD) % 8;
      m_bnd     = (cyc % FRAME) == FRAME - 1;
      m_nib     = m_shadow[m_digit*4 +: 4];
      m_blank   = (m_digit > 0) && i_blank_lz && ((m_shadow >> (4 * m_digit)) == 32'd0);
      exp_sel   = i_en ? ~(8'h01 << m_digit) : 8'hFF;
      exp_seg   = !i_en ? 8'hFF : (m_blank ? 8'hFF : GLYPH[m_nib]);
      exp_frame = i_en && m_bnd;
      if (!i_en || m_bnd) m_shadow = i_data;
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("model_seg", o_seg, exp_seg);
    check("model_sel", o_sel, exp_sel);
    check("model_frame", {7'b0, o_frame}, {7'b0, exp_frame});
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Lands on the cycle where o_frame is high, with the new value already in the shadow.
  task automatic wait_frame();
    int k;
    k = 0;
    step();
    while (!o_frame && k < 3 * FRAME) begin
      step();
      k++;
    end
    check("frame_wait", {7'b0, o_frame}, 8'h01);
  endtask

  function automatic logic [7:0] sel_of(input int d);
    logic [7:0] s;
    s = 8'h01 << d;
    return ~s;
  endfunction

  logic [15:0] seen;

  initial begin
    rst        = 1'b1;
    i_en       = 1'b1;
    i_blank_lz = 1'b0;
    i_data     = 32'h1234_5678;

    repeat (3) begin
      step();
      check("rst_seg", o_seg, 8'hFF);
      check("rst_sel", o_sel, 8'hFF);
      check("rst_frame", {7'b0, o_frame}, 8'h00);
    end
    rst = 1'b0;

    // First frame shows the reset shadow (zero) on every digit.
    for (int k = 1; k <= FRAME; k++) begin
      step();
      check("f0_sel", o_sel, sel_of((k - 1) / SD));
      check("f0_seg", o_seg, 8'hC0);
      check("f0_frame", {7'b0, o_frame}, (k == FRAME) ? 8'h01 : 8'h00);
    end

    for (int k = 1; k <= FRAME; k++) begin
      step();
      check("f1_seg", o_seg, DIG_12345678[(k - 1) / SD]);
      check("f1_sel", o_sel, sel_of((k - 1) / SD));
      check("f1_frame", {7'b0, o_frame}, (k == FRAME) ? 8'h01 : 8'h00);
      if (k == 8) i_data = 32'hFFFF_FFFF;
    end
    step();
    check("f2_seg", o_seg, 8'h8E);

    i_data     = 32'h0000_00A0;
    i_blank_lz = 1'b1;
    wait_frame();
    for (int k = 0; k < FRAME; k++) begin
      step();
      check("lz_a0_seg", o_seg, (k / SD == 0) ? 8'hC0 : ((k / SD == 1) ? 8'h88 : 8'hFF));
      check("lz_a0_sel", o_sel, sel_of(k / SD));
    end
    i_data = 32'h0;
    wait_frame();
    for (int k = 0; k < FRAME; k++) begin
      step();
      check("lz_zero_seg", o_seg, (k / SD == 0) ? 8'hC0 : 8'hFF);
      check("lz_zero_sel", o_sel, sel_of(k / SD));
    end
    i_blank_lz = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      check("nolz_seg", o_seg, 8'hC0);
    end

    // Enable behaviour, starting at a frame boundary.
    steps(10);
    i_en = 1'b0;
    step();
    check("dis_seg", o_seg, 8'hFF);
    check("dis_sel", o_sel, 8'hFF);
    steps(3);
    i_data = 32'hDEAD_BEEF;
    step();
    i_en = 1'b1;
    step();
    check("en_seg", o_seg, 8'h83);
    check("en_sel", o_sel, 8'hF7);
    for (int s = 17; s <= FRAME; s++) begin
      step();
      check("en_frame", {7'b0, o_frame}, (s == FRAME) ? 8'h01 : 8'h00);
    end
    step();
    check("en_next_seg", o_seg, 8'h8E);

    // Reset while digit 5 is being scanned with a new value pending.
    steps(20);
    i_data = 32'h5555_5555;
    rst    = 1'b1;
    step();
    check("mrst_seg", o_seg, 8'hFF);
    check("mrst_sel", o_sel, 8'hFF);
    rst = 1'b0;
    step();
    check("mrst_first_sel", o_sel, 8'hFE);
    check("mrst_first_seg", o_seg, 8'hC0);
    for (int k = 2; k <= FRAME; k++) begin
      step();
      check("mrst_hold_seg", o_seg, 8'hC0);
      check("mrst_frame", {7'b0, o_frame}, (k == FRAME) ? 8'h01 : 8'h00);
    end
    step();
    check("mrst_new_seg", o_seg, 8'h92);

    seen   = 16'h0;
    i_data = 32'hFEDC_BA98;
    wait_frame();
    i_data = 32'h7654_3210;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      for (int g = 0; g < 16; g++)
        if (o_seg == GLYPH[g]) seen[g] = 1'b1;
    end
    for (int g = 0; g < 16; g++)
      check($sformatf("glyph_%0h", g), {7'b0, seen[g]}, 8'h01);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) i_data = $urandom;
      i_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) i_blank_lz = ~i_blank_lz;
      if ($urandom_range(0, 3) == 0) i_data = i_data >> (4 * $urandom_range(1, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
